packet_deframer: RTL and testbench
==================================

PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, width of every stream word.
REQ-002 The module SHALL have parameter DELIMITER, default 0, the end-of-packet word value.
REQ-003 The module SHALL have parameter ESCAPE, default 8'hDB, the escape word value; it is used only with PACKET_DEFRAMER_ESCAPE_EN.
REQ-004 The module SHALL have parameter MAX_LEN, default 1024, the maximum payload words per packet; legal range is 2 or more.
REQ-005 The ports SHALL be, in order:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  DATA_WIDTH  encoded stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  module accepts in_data.
- out_data  output  DATA_WIDTH  decoded payload word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts.
- out_last  output  1  final word of packet, qualified by out_valid.
- overflow  output  1  one-cycle pulse: packet truncated at MAX_LEN.

Function
REQ-006 A transfer SHALL occur on a port only in a cycle where valid and ready are both high at the rising edge.
REQ-007 in_ready SHALL equal (!out_valid || out_ready), be combinational, and not depend on in_valid.
REQ-008 The datapath SHALL be a hold register H (one word plus a valid bit) followed by an output register O (data, last, valid).
REQ-009 O SHALL be cleared (out_valid low) after a transfer in which out_ready is high, unless O is reloaded in the same cycle.
REQ-010 Accepting a payload word w with H valid SHALL move H to O with last=0 and load w into H.
REQ-011 Accepting a payload word w with H empty SHALL load w into H; O is unchanged.
REQ-012 Accepting a delimiter with H valid SHALL move H to O with last=1 and empty H.
REQ-013 Accepting a delimiter with H empty SHALL produce no output, so empty packets are dropped silently.
REQ-014 Latency SHALL be: a word appears on out_data on the cycle after the next payload word or delimiter is accepted; there is no timeout flush.
REQ-015 The state machine SHALL have states RUN, ESC and DISCARD; the reset state SHALL be RUN.
REQ-016 A per-packet counter SHALL count words loaded into H, with width $clog2(MAX_LEN+1); it clears on each delimiter and on entry to DISCARD.
REQ-017 In RUN, accepting a payload word while H holds the MAX_LEN-th word SHALL:
- move H to O with last=1,
- leave H empty,
- pulse overflow high for exactly one cycle,
- enter DISCARD.
REQ-018 In RUN, a delimiter arriving while H holds the MAX_LEN-th word SHALL end the packet normally with no overflow.
REQ-019 In DISCARD, accepted words SHALL be dropped; an accepted delimiter SHALL return the machine to RUN; in_ready still follows REQ-007.
REQ-020 A packet of exactly MAX_LEN words followed by its delimiter SHALL be emitted intact.
REQ-021 When out_valid is high and out_ready is low, out_data and out_last SHALL be held stable.

Reset
REQ-022 Under reset, all of the following SHALL be 0: out_valid, out_last, out_data, overflow, H valid, H data and the counter; the state SHALL be RUN.
REQ-023 Reset mid-packet SHALL discard any partial packet; the first word accepted after reset starts a new packet.
REQ-024 in_ready SHALL be high during reset.

Configuration
REQ-025 With PACKET_DEFRAMER_ESCAPE_EN defined, accepting ESCAPE in RUN SHALL:
- be consumed without output,
- move the state to ESC.
REQ-026 In ESC, the next accepted word, including DELIMITER or ESCAPE, SHALL be treated as a payload word under REQ-010, REQ-011 and REQ-017, and the state SHALL return to RUN; if REQ-017 applies, the state goes to DISCARD instead.
REQ-027 Without PACKET_DEFRAMER_ESCAPE_EN, ESCAPE SHALL be an ordinary payload word, and the ESC state and its logic SHALL be absent.

Verification
REQ-028 The bench SHALL cover: input 11,22,33,00 with out_ready=1 -> output 11(l0),22(l0),33(l1); each word appears one cycle after the following accept.
REQ-029 The bench SHALL cover: input 00,00,44,00 -> output 44(l1) only; no output for the empty packets.
REQ-030 The bench SHALL cover: MAX_LEN=4, input 1,2,3,4,5,6,00,7,00 -> output 1,2,3,4(l1); one overflow pulse when 5 is accepted; then 7(l1).
REQ-031 The bench SHALL cover: out_ready held low 5 cycles mid-packet -> in_ready low, out_data and out_last stable, no words lost or duplicated.
REQ-032 With ESCAPE_EN, the bench SHALL cover: input 55,DB,00,DB,DB,00 -> output 55(l0),00(l0),DB(l1).
REQ-033 The bench SHALL cover: reset asserted after 2 of 3 payload words of a packet -> out_valid low, then 9A,00 -> output 9A(l1) only.

Source files
------------

// File: rtl/packet_deframer.sv
// Delimiter-framed stream deframer: a hold register H delays each word so the last
// word of a packet can be tagged; packets over MAX_LEN are truncated. Optional macro: PACKET_DEFRAMER_ESCAPE_EN.
module packet_deframer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIMITER  = '0,
  parameter logic [DATA_WIDTH-1:0] ESCAPE     = DATA_WIDTH'(8'hDB),
  parameter int                    MAX_LEN    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow
);

  localparam int             CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_LEN);
`ifdef PACKET_DEFRAMER_ESCAPE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  if (MAX_LEN < 2 || (ESC_EN && ESCAPE == DELIMITER)) begin : g_bad_cfg
    $error("packet_deframer: illegal parameter set");
  end

`ifdef PACKET_DEFRAMER_ESCAPE_EN
  typedef enum logic [1:0] {RUN = 2'd0, DISCARD = 2'd1, ESC = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, DISCARD = 2'd1} state_t;
`endif

  state_t                r_state;
  state_t                w_nxt;
  logic                  r_h_valid;
  logic [DATA_WIDTH-1:0] r_h_data;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_o_data;
  logic                  r_o_last;
  logic                  r_o_valid;
  logic                  r_ovf;

  logic w_accept;
  logic w_pay;
  logic w_delim;
  logic w_o_load;
  logic w_o_last;
  logic w_h_load;
  logic w_h_clr;
  logic w_cnt_clr;
  logic w_ovf;

  assign in_ready  = !r_o_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_data  = r_o_data;
  assign out_valid = r_o_valid;
  assign out_last  = r_o_last;
  assign overflow  = r_ovf;

  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_pay     = 1'b0;
    w_delim   = 1'b0;
    w_o_load  = 1'b0;
    w_o_last  = 1'b0;
    w_h_load  = 1'b0;
    w_h_clr   = 1'b0;
    w_cnt_clr = 1'b0;
    w_ovf     = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        RUN: begin
          if (in_data == DELIMITER) w_delim = 1'b1;
`ifdef PACKET_DEFRAMER_ESCAPE_EN
          else if (in_data == ESCAPE) w_nxt = ESC;
`endif
          else w_pay = 1'b1;
        end
`ifdef PACKET_DEFRAMER_ESCAPE_EN
        ESC: begin
          w_pay = 1'b1;
          w_nxt = RUN;
        end
`endif
        DISCARD: begin
          if (in_data == DELIMITER) begin
            w_nxt     = RUN;
            w_cnt_clr = 1'b1;
          end
        end
        default: w_nxt = RUN;
      endcase

      if (w_delim) begin
        w_cnt_clr = 1'b1;
        if (r_h_valid) begin
          w_o_load = 1'b1;
          w_o_last = 1'b1;
          w_h_clr  = 1'b1;
        end
      end

      // A word arriving while H already holds the MAX_LEN-th word truncates the packet.
      if (w_pay) begin
        if (r_h_valid && r_cnt == MAX_CNT) begin
          w_o_load  = 1'b1;
          w_o_last  = 1'b1;
          w_h_clr   = 1'b1;
          w_cnt_clr = 1'b1;
          w_ovf     = 1'b1;
          w_nxt     = DISCARD;
        end else begin
          w_h_load = 1'b1;
          w_o_load = r_h_valid;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
      r_cnt     <= '0;
      r_o_data  <= '0;
      r_o_last  <= 1'b0;
      r_o_valid <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_ovf;

      if (w_o_load) begin
        r_o_data  <= r_h_data;
        r_o_last  <= w_o_last;
        r_o_valid <= 1'b1;
      end else if (out_ready) begin
        r_o_valid <= 1'b0;
      end

      if (w_h_load) begin
        r_h_data  <= in_data;
        r_h_valid <= 1'b1;
      end else if (w_h_clr) begin
        r_h_valid <= 1'b0;
      end

      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_h_load) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// Bench for packet_deframer: queue-based packet model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with backpressure and resets.
module tb_packet_deframer;

  localparam int         ML    = 4;
  localparam logic [7:0] DELIM = 8'h00;
  localparam logic [7:0] ESCW  = 8'hDB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       overflow;

  packet_deframer #(
    .DATA_WIDTH(8),
    .DELIMITER (DELIM),
    .ESCAPE    (ESCW),
    .MAX_LEN   (ML)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the current packet as a queue; every payload word except the
  // newest is known not-last, so it is released as soon as the next word arrives.
  logic [7:0] m_pkt[$];
  logic [8:0] m_out[$];
  bit         m_disc;
  bit         m_esc;
  logic       m_ovf;
  bit         m_acc;
  bit         chk_en = 1'b0;

  function automatic void m_payload(input logic [7:0] w);
    if (m_pkt.size() == ML) begin
      m_out.push_back({1'b1, m_pkt[$]});
      m_pkt.delete();
      m_ovf  = 1'b1;
      m_disc = 1'b1;
    end else begin
      if (m_pkt.size() > 0) m_out.push_back({1'b0, m_pkt[$]});
      m_pkt.push_back(w);
    end
  endfunction

  function automatic void m_word(input logic [7:0] w);
    if (m_disc) begin
      if (w == DELIM) m_disc = 1'b0;
      return;
    end
`ifdef PACKET_DEFRAMER_ESCAPE_EN
    if (m_esc) begin
      m_esc = 1'b0;
      m_payload(w);
      return;
    end
    if (w == ESCW) begin
      m_esc = 1'b1;
      return;
    end
`endif
    if (w == DELIM) begin
      if (m_pkt.size() > 0) m_out.push_back({1'b1, m_pkt[$]});
      m_pkt.delete();
      return;
    end
    m_payload(w);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_pkt.delete();
      m_out.delete();
      m_disc = 1'b0;
      m_esc  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_acc = in_valid && (m_out.size() == 0 || out_ready);
      if (m_out.size() != 0 && out_ready) void'(m_out.pop_front());
      m_ovf = 1'b0;
      if (m_acc) m_word(in_data);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (m_out.size() == 0) || out_ready);
      chk("out_valid", out_valid, m_out.size() != 0);
      if (m_out.size() != 0) begin
        chk("out_data", out_data, m_out[0][7:0]);
        chk("out_last", out_last, m_out[0][8]);
      end
      chk("overflow", overflow, m_ovf);
    end
  end

  // Log of DUT handshakes for the literal scenario checks.
  logic [8:0] dlog[$];
  logic [8:0] want[$];
  int         ovf_seen = 0;

  always @(posedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) dlog.push_back({out_last, out_data});
      if (overflow) ovf_seen++;
    end
  end

  bit rnd_rdy = 1'b0;
  always @(posedge clock) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic send(input logic [7:0] w);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %0h never accepted, required accept within 200 cycles", w);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, dlog.size(), want.size());
    for (int i = 0; i < dlog.size() && i < want.size(); i++)
      chk($sformatf("%s[%0d]", name, i), dlog[i], want[i]);
    dlog.delete();
  endtask

  initial begin
    int r;
    logic [7:0] w;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    do_reset();
    dlog.delete();

    // Basic packet, with literal latency checks.
    send(8'h11);
    chk("lat_first_none", out_valid, 1'b0);
    send(8'h22);
    chk("lat_11_valid", out_valid, 1'b1);
    chk("lat_11_data", out_data, 8'h11);
    send(8'h33);
    send(8'h00);
    chk("lat_33_last", {out_valid, out_last, out_data}, {2'b11, 8'h33});
    drain();
    want = '{9'h011, 9'h022, 9'h133};
    check_log("basic");

    // Empty packets vanish.
    send(8'h00); send(8'h00); send(8'h44); send(8'h00);
    drain();
    want = '{9'h144};
    check_log("empty");

    // Truncation at MAX_LEN.
    ovf_seen = 0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    chk("ovf_pulse_on_5", overflow, 1'b1);
    send(8'h06); send(8'h00); send(8'h07); send(8'h00);
    drain();
    chk("ovf_count", ovf_seen, 1);
    want = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h107};
    check_log("trunc");

    // Exactly MAX_LEN words then delimiter is intact.
    ovf_seen = 0;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'h00);
    drain();
    chk("full_no_ovf", ovf_seen, 0);
    want = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
    check_log("full");

    // Backpressure mid-packet.
    send(8'h10); send(8'h20); send(8'h30);
    out_ready = 1'b0;
    in_data   = 8'h40;
    in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", {out_valid, out_last, out_data}, {2'b10, 8'h20});
    end
    out_ready = 1'b1;
    send(8'h40);
    send(8'h00);
    drain();
    want = '{9'h010, 9'h020, 9'h030, 9'h140};
    check_log("bp");

`ifdef PACKET_DEFRAMER_ESCAPE_EN
    send(8'h55); send(8'hDB); send(8'h00); send(8'hDB); send(8'hDB); send(8'h00);
    drain();
    want = '{9'h055, 9'h000, 9'h1DB};
    check_log("escape");
`else
    send(8'h55); send(8'hDB); send(8'h00);
    drain();
    want = '{9'h055, 9'h1DB};
    check_log("esc_plain");
`endif

    // Reset mid-packet discards the partial packet.
    out_ready = 1'b0;
    send(8'h31); send(8'h32);
    do_reset();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    dlog.delete();
    send(8'h9A); send(8'h00);
    drain();
    want = '{9'h19A};
    check_log("mid_rst");

    // Random traffic against the model.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 18)      w = DELIM;
      else if (r < 25) w = ESCW;
      else             w = 8'($urandom_range(1, 255));
      send(w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      if (i % 311 == 200) begin
        rnd_rdy = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
        rnd_rdy = 1'b1;
      end
    end
    send(DELIM);
    rnd_rdy = 1'b0;
    @(posedge clock);
    #1;
    drain();
    chk("final_drained", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
